hps_fpga_sw_ctrl: RTL

Avalon-MM controller for the 4-bit switch input port of the HPS–FPGA bridge. Adds synchronization, per-bit debounce, edge capture and a maskable interrupt to the raw switch levels. Exposes four 32-bit registers to the HPS lightweight bridge. Replaces direct polling of raw switch levels by software.

---
 rtl/hps_fpga_sw_pkg.sv | 17 +
 rtl/sw_debounce.sv | 94 +++++++++
 rtl/hps_fpga_sw_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/hps_fpga_sw_pkg.sv
// Shared constants for the HPS-FPGA switch controller: register map, CONFIG bits, debounce states.
package hps_fpga_sw_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
    localparam logic [1:0] ADDR_CONFIG   = 2'd3;

    localparam int unsigned CFG_EDGE_ANY = 0;
    localparam int unsigned CFG_IRQ_EN   = 1;

    typedef enum logic {
        STABLE,
        PENDING
    } db_state_e;

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchronizer followed by a debounce filter.
// The filter is built only when SW_DEBOUNCE_EN is defined; otherwise stable follows sync_q.
module sw_debounce
    import hps_fpga_sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic in_i,
    output logic stable_o
);

    if (DEBOUNCE_CYCLES < 2 || CNT_W < 1 || CNT_W > 31 ||
        (32'd1 << CNT_W) < DEBOUNCE_CYCLES) begin : g_bad_params
        $error("sw_debounce: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
    end

    logic sync1_q, sync_q, stable_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync1_q <= in_i;
            sync_q  <= sync1_q;
        end
    end

`ifdef SW_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             stable_d, differ, accept;

    assign differ  = (sync_q != stable_q);
    // The first differing sample counts as 1, so a new level is taken on the
    // (DEBOUNCE_CYCLES-1)th consecutive differing sample.
    assign cnt_inc = (state_q == STABLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign accept  = differ && (cnt_inc == CntLast);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= STABLE;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        unique case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (accept) begin
                    stable_d = sync_q;
                end else if (differ) begin
                    state_d = PENDING;
                    cnt_d   = cnt_inc;
                end
            end
            PENDING: begin
                if (!differ || accept) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    if (accept) stable_d = sync_q;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = STABLE;
        endcase
    end
`else
    always_ff @(posedge clk_i) begin
        if (reset_i) stable_q <= 1'b0;
        else         stable_q <= sync_q;
    end
`endif

    always_comb begin
        stable_o = stable_q;
    end

endmodule

// File: rtl/hps_fpga_sw_ctrl.sv
// Avalon-MM switch port controller: debounced DATA, IRQ_MASK, W1C EDGE_CAP, CONFIG and level irq.
// Define SW_DEBOUNCE_EN to build the per-bit debounce filters.
module hps_fpga_sw_ctrl
    import hps_fpga_sw_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable, stable_prev_q, edge_set, cap_clr;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d, irq_mask_q, irq_mask_d;
    logic [1:0]       cfg_q, cfg_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             unused_wd;

    assign unused_wd = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk_i   (clk),
            .reset_i (reset),
            .in_i    (in_port[i]),
            .stable_o(stable[i])
        );
    end

    assign edge_set = (stable & ~stable_prev_q) |
                      ({WIDTH{cfg_q[CFG_EDGE_ANY]}} & ~stable & stable_prev_q);

    always_comb begin
        irq_mask_d = irq_mask_q;
        cfg_d      = cfg_q;
        cap_clr    = '0;
        if (write) begin
            case (address)
                ADDR_IRQ_MASK: irq_mask_d = writedata[WIDTH-1:0];
                ADDR_EDGE_CAP: cap_clr    = writedata[WIDTH-1:0];
                ADDR_CONFIG:   cfg_d      = writedata[1:0];
                default:       ;
            endcase
        end
        // A capture in the same cycle as its clear must not be lost.
        edge_cap_d = (edge_cap_q & ~cap_clr) | edge_set;
        irq_d      = cfg_q[CFG_IRQ_EN] & |(edge_cap_q & irq_mask_q);
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d = 32'(stable);
            ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
            ADDR_EDGE_CAP: readdata_d = 32'(edge_cap_q);
            ADDR_CONFIG:   readdata_d = 32'(cfg_q);
            default:       readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_prev_q <= '0;
            edge_cap_q    <= '0;
            irq_mask_q    <= '0;
            cfg_q         <= '0;
            readdata_q    <= '0;
            irq_q         <= 1'b0;
        end else begin
            stable_prev_q <= stable;
            edge_cap_q    <= edge_cap_d;
            irq_mask_q    <= irq_mask_d;
            cfg_q         <= cfg_d;
            readdata_q    <= readdata_d;
            irq_q         <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
